// File: rtl/poly_synth_core_if.sv
// Control and audio signals of the polyphonic synth core.
// Keypad/divider side drives notes; the core returns voice state and audio.
interface poly_synth_core_if #(
   parameter int VOICES = 4,
   parameter int KEY_W  = 4,
   parameter int DIV_W  = 16
);
   logic              en;
   logic              note_on;
   logic              note_off;
   logic [KEY_W-1:0]  note_key;
   logic [DIV_W-1:0]  divider_i;
   logic [1:0]        mode;
   logic [VOICES-1:0] active_o;
   logic [7:0]        sample_o;
   logic              pwm_o;

   modport master (
      output en, note_on, note_off, note_key, divider_i, mode,
      input  active_o, sample_o, pwm_o
   );

   modport slave (
      input  en, note_on, note_off, note_key, divider_i, mode,
      output active_o, sample_o, pwm_o
   );
endinterface

// File: rtl/poly_synth_core.sv
// Polyphonic synth: voice allocation, per-voice oscillators,
// sequential phase-to-amplitude sweep, mixer and 8-bit PWM output.
module poly_synth_core #(
   parameter int VOICES     = 4,
   parameter int KEY_W      = 4,
   parameter int DIV_W      = 16,
   parameter int SAMPLE_DIV = 1000
) (
   input logic             clk,
   input logic             n_rst,
   poly_synth_core_if.slave bus
);
   localparam int LV = $clog2(VOICES);
   localparam int AW = 8 + LV;
   localparam int TW = $clog2(SAMPLE_DIV);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_ACC, S_PUB} state_t;

   logic [VOICES-1:0] active_q, active_d;
   logic [KEY_W-1:0]  key_q [VOICES];
   logic [KEY_W-1:0]  key_d [VOICES];
   logic [DIV_W-1:0]  div_q [VOICES];
   logic [DIV_W-1:0]  div_d [VOICES];
   logic [DIV_W-1:0]  cnt_q [VOICES];
   logic [DIV_W-1:0]  cnt_d [VOICES];
   logic [LV-1:0]     steal_q, steal_d;
   logic [TW-1:0]     tick_q, tick_d;
   logic              tick;
   logic [7:0]        pwm_cnt_q, pwm_cnt_d;
   logic              pwm_q, pwm_d;

   logic              hit, free;
   logic [LV-1:0]     hit_idx, free_idx, tgt;

   state_t            state_q;
   logic [LV-1:0]     voice_q;
   logic [2:0]        bit_q;
   logic [DIV_W-1:0]  rem_q;
   logic [7:0]        quo_q;
   logic [AW-1:0]     acc_q;
   logic [7:0]        sample_q;
   logic [1:0]        snap_mode_q;
   logic [VOICES-1:0] snap_act_q;
   logic [DIV_W-1:0]  snap_cnt_q [VOICES];
   logic [DIV_W-1:0]  snap_div_q [VOICES];

   logic [DIV_W:0]    rem_sh;
   logic              q_bit;
   logic [DIV_W-1:0]  rem_nxt;
   logic [7:0]        amp;

   function automatic logic [7:0] shape(input logic [1:0] m,
                                        input logic [7:0] q);
      logic [7:0] r;
      r = 8'd0;
      unique case (m)
         2'd0: r = q[7] ? 8'd0 : 8'd255;
         2'd1: r = q;
         2'd2: r = q[7] ? {~q[6:0], 1'b0} : {q[6:0], 1'b0};
         2'd3: r = 8'd0;
         default: r = 8'd0;
      endcase
      return r;
   endfunction

   assign tick = bus.en && (tick_q == TW'(SAMPLE_DIV - 1));

   // Oscillators advance, then note_off clears, then note_on allocates.
   always_comb begin
      active_d = active_q;
      key_d    = key_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      steal_d  = steal_q;
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int v = 0; v < VOICES; v++) begin
         if (!active_q[v])
            cnt_d[v] = '0;
         else if (bus.en)
            cnt_d[v] = (cnt_q[v] == div_q[v] - DIV_W'(1)) ?
                       '0 : cnt_q[v] + DIV_W'(1);
      end
      if (bus.note_off) begin
         for (int v = 0; v < VOICES; v++) begin
            if (active_q[v] && key_q[v] == bus.note_key) begin
               active_d[v] = 1'b0;
               cnt_d[v]    = '0;
            end
         end
      end
      for (int v = VOICES - 1; v >= 0; v--) begin
         if (active_d[v] && key_q[v] == bus.note_key) begin
            hit     = 1'b1;
            hit_idx = LV'(v);
         end
         if (!active_d[v]) begin
            free     = 1'b1;
            free_idx = LV'(v);
         end
      end
      tgt = steal_q;
      if (free) tgt = free_idx;
      if (hit)  tgt = hit_idx;
      if (bus.note_on && bus.divider_i != '0) begin
         if (!hit && !free) steal_d = steal_q + LV'(1);
         active_d[tgt] = 1'b1;
         key_d[tgt]    = bus.note_key;
         div_d[tgt]    = bus.divider_i;
         cnt_d[tgt]    = '0;
      end
   end

   // Sample-rate counter and PWM next state; both freeze when disabled.
   always_comb begin
      tick_d    = tick_q;
      pwm_cnt_d = pwm_cnt_q;
      pwm_d     = 1'b0;
      if (bus.en) begin
         tick_d    = tick ? '0 : tick_q + TW'(1);
         pwm_cnt_d = pwm_cnt_q + 8'd1;
         pwm_d     = pwm_cnt_q < sample_q;
      end
   end

   // One restoring-division step and the shaped amplitude of the voice.
   always_comb begin
      rem_sh  = {rem_q, 1'b0};
      q_bit   = rem_sh >= {1'b0, snap_div_q[voice_q]};
      rem_nxt = q_bit ? DIV_W'(rem_sh - {1'b0, snap_div_q[voice_q]}) :
                        rem_sh[DIV_W-1:0];
      amp     = snap_act_q[voice_q] ? shape(snap_mode_q, quo_q) : 8'd0;
   end

   // Voice table, tick counter and PWM registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         active_q  <= '0;
         steal_q   <= '0;
         tick_q    <= '0;
         pwm_cnt_q <= '0;
         pwm_q     <= 1'b0;
         for (int v = 0; v < VOICES; v++) begin
            key_q[v] <= '0;
            div_q[v] <= '0;
            cnt_q[v] <= '0;
         end
      end else begin
         active_q  <= active_d;
         key_q     <= key_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         steal_q   <= steal_d;
         tick_q    <= tick_d;
         pwm_cnt_q <= pwm_cnt_d;
         pwm_q     <= pwm_d;
      end
   end

   // Sweep: snapshot at tick, 8 divide steps + 1 accumulate per voice.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         voice_q     <= '0;
         bit_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         acc_q       <= '0;
         sample_q    <= '0;
         snap_mode_q <= '0;
         snap_act_q  <= '0;
         for (int v = 0; v < VOICES; v++) begin
            snap_cnt_q[v] <= '0;
            snap_div_q[v] <= '0;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (tick) begin
                  snap_mode_q <= bus.mode;
                  snap_act_q  <= active_q;
                  snap_cnt_q  <= cnt_q;
                  snap_div_q  <= div_q;
                  rem_q       <= cnt_q[0];
                  quo_q       <= '0;
                  acc_q       <= '0;
                  voice_q     <= '0;
                  bit_q       <= '0;
                  state_q     <= S_DIV;
               end
            end
            S_DIV: begin
               rem_q <= rem_nxt;
               quo_q <= {quo_q[6:0], q_bit};
               bit_q <= bit_q + 3'd1;
               if (bit_q == 3'd7) state_q <= S_ACC;
            end
            S_ACC: begin
               acc_q <= acc_q + AW'(amp);
               if (voice_q == LV'(VOICES - 1)) begin
                  state_q <= S_PUB;
               end else begin
                  voice_q <= voice_q + LV'(1);
                  rem_q   <= snap_cnt_q[voice_q + LV'(1)];
                  quo_q   <= '0;
                  state_q <= S_DIV;
               end
            end
            S_PUB: begin
               sample_q <= 8'(acc_q >> LV);
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.active_o = active_q;
   assign bus.sample_o = sample_q;
   assign bus.pwm_o    = pwm_q;
endmodule
